// File: rtl/vx_reset_seq_pkg.sv
// Shared types and constants for the socket reset sequencer.
// Holds the sequencer state encoding, default domain indices,
// the startup DCR address/value and a small constant helper.
package vx_reset_seq_pkg;

    typedef enum logic [2:0] {
        ASSERT_HOLD,
        RELEASE_PRE,
        WAIT_LOAD,
        DCR_WRITE,
        RELEASE_POST,
        RUN
    } reset_seq_state_t;

    // Default domain indices; index order is release order.
    localparam int DOM_MEM_LOAD = 0;
    localparam int DOM_MEM      = 1;
    localparam int DOM_MEM_ARB  = 2;
    localparam int DOM_ICACHE   = 3;
    localparam int DOM_DCACHE   = 4;
    localparam int DOM_GBAR     = 5;
    localparam int DOM_CORE     = 6;

    // DCR register holding the low word of the core startup address,
    // and the code base address the cores start fetching from.
    localparam logic [11:0] VX_DCR_BASE_STARTUP_ADDR0 = 12'h001;
    localparam logic [31:0] USER_BASE_ADDR            = 32'h8000_0000;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vx_reset_seq_timer.sv
// Loadable down-counter with a zero flag.
// Used by the reset sequencer for hold/gap spacing and, when
// VX_RESET_SEQ_TIMEOUT_EN is defined, for the preload timeout.
// The counter saturates at zero; a load takes priority over a decrement.
module vx_reset_seq_timer
    import vx_reset_seq_pkg::*;
#(
    parameter int               WIDTH = 3,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: reload, step down toward zero, or hold.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Count register; comes out of reset already loaded with INIT.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= INIT;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/vx_reset_sequencer.sv
// Socket reset sequencer: releases NUM_DOMAINS active-high domain resets
// in index order, holds the post-load domains until memory preload is
// done, issues the startup-address DCR write, then releases the rest.
// Optional feature macro: VX_RESET_SEQ_TIMEOUT_EN (preload timeout).
module vx_reset_sequencer
    import vx_reset_seq_pkg::*;
#(
    parameter int                        NUM_DOMAINS      = 7,
    parameter int                        NUM_PRELOAD      = 2,
    parameter int                        HOLD_CYCLES      = 4,
    parameter int                        GAP_CYCLES       = 2,
    parameter int                        DCR_ADDR_WIDTH   = 12,
    parameter int                        DCR_DATA_WIDTH   = 32,
    parameter logic [DCR_ADDR_WIDTH-1:0] STARTUP_DCR_ADDR = DCR_ADDR_WIDTH'(VX_DCR_BASE_STARTUP_ADDR0),
    parameter logic [DCR_DATA_WIDTH-1:0] STARTUP_ADDR     = DCR_DATA_WIDTH'(USER_BASE_ADDR)
`ifdef VX_RESET_SEQ_TIMEOUT_EN
    ,
    parameter int                        LOAD_TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      soft_reset_req,
    input  logic                      load_done,
    output logic [NUM_DOMAINS-1:0]    domain_reset,
    output logic                      dcr_write_valid,
    output logic [DCR_ADDR_WIDTH-1:0] dcr_write_addr,
    output logic [DCR_DATA_WIDTH-1:0] dcr_write_data,
    output logic                      seq_busy,
    output logic                      seq_done,
    output logic                      load_timeout
);

    localparam int CNT_W = $clog2(maxInt(HOLD_CYCLES, GAP_CYCLES) + 1);
    localparam int IDX_W = $clog2(NUM_DOMAINS + 1);

    localparam logic [CNT_W-1:0]       HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]       GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0]       LAST_PRE  = IDX_W'((NUM_PRELOAD > 0) ? NUM_PRELOAD - 1 : 0);
    localparam logic [IDX_W-1:0]       LAST_DOM  = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [NUM_DOMAINS-1:0] ALL_ONES  = {NUM_DOMAINS{1'b1}};

    reset_seq_state_t       state_q, state_d;
    logic [NUM_DOMAINS-1:0] domReset_q, domReset_d;
    logic [IDX_W-1:0]       idx_q, idx_d;

    logic             timerLoad;
    logic [CNT_W-1:0] timerLoadVal;
    logic             timerDec;
    logic             timerZero;
    logic             timeoutFire;

    // The timer holds the remaining edges before the next release; it
    // leaves reset loaded with the hold time so edge HOLD_CYCLES releases.
    vx_reset_seq_timer #(
        .WIDTH (CNT_W),
        .INIT  (HOLD_LOAD)
    ) u_gapTimer (
        .clk_i      (clk),
        .rst_ni     (reset_n),
        .load_i     (timerLoad),
        .load_val_i (timerLoadVal),
        .dec_i      (timerDec),
        .zero_o     (timerZero)
    );

    // Next-state logic: step through hold, pre-load releases, preload wait,
    // DCR write and post-load releases; only RUN reacts to a soft reset.
    always_comb begin
        state_d      = state_q;
        domReset_d   = domReset_q;
        idx_d        = idx_q;
        timerLoad    = 1'b0;
        timerLoadVal = GAP_LOAD;
        timerDec     = 1'b0;

        unique case (state_q)
            ASSERT_HOLD, RELEASE_PRE: begin
                if (!timerZero) begin
                    timerDec = 1'b1;
                end else if (NUM_PRELOAD == 0) begin
                    state_d = WAIT_LOAD;
                end else begin
                    domReset_d[idx_q] = 1'b0;
                    idx_d             = idx_q + IDX_W'(1);
                    timerLoad         = 1'b1;
                    state_d           = (idx_q == LAST_PRE) ? WAIT_LOAD : RELEASE_PRE;
                end
            end
            WAIT_LOAD: begin
                if (load_done || timeoutFire) begin
                    state_d = DCR_WRITE;
                end
            end
            DCR_WRITE: begin
                timerLoad = 1'b1;
                state_d   = RELEASE_POST;
            end
            RELEASE_POST: begin
                if (!timerZero) begin
                    timerDec = 1'b1;
                end else begin
                    domReset_d[idx_q] = 1'b0;
                    idx_d             = idx_q + IDX_W'(1);
                    timerLoad         = 1'b1;
                    if (idx_q == LAST_DOM) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (soft_reset_req) begin
                    domReset_d   = ALL_ONES;
                    idx_d        = '0;
                    timerLoad    = 1'b1;
                    timerLoadVal = HOLD_LOAD;
                    state_d      = ASSERT_HOLD;
                end
            end
            default: begin
                state_d = ASSERT_HOLD;
            end
        endcase
    end

    // Sequencer registers; reset_n forces every domain back into reset at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ASSERT_HOLD;
            domReset_q <= ALL_ONES;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            domReset_q <= domReset_d;
            idx_q      <= idx_d;
        end
    end

`ifdef VX_RESET_SEQ_TIMEOUT_EN
    localparam int              TO_W    = $clog2(LOAD_TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(LOAD_TIMEOUT_CYCLES - 1);

    logic toZero;
    logic loadTimeout_q;

    // Reloaded whenever we are outside WAIT_LOAD, counts down inside it.
    vx_reset_seq_timer #(
        .WIDTH (TO_W),
        .INIT  (TO_LOAD)
    ) u_timeoutTimer (
        .clk_i      (clk),
        .rst_ni     (reset_n),
        .load_i     (state_q != WAIT_LOAD),
        .load_val_i (TO_LOAD),
        .dec_i      (state_q == WAIT_LOAD),
        .zero_o     (toZero)
    );

    assign timeoutFire = (state_q == WAIT_LOAD) && toZero && !load_done;

    // Sticky timeout flag; only reset_n clears it, a soft reset does not.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            loadTimeout_q <= 1'b0;
        end else if (timeoutFire) begin
            loadTimeout_q <= 1'b1;
        end
    end

    assign load_timeout = loadTimeout_q;
`else
    assign timeoutFire  = 1'b0;
    assign load_timeout = 1'b0;
`endif

    assign domain_reset    = domReset_q;
    assign dcr_write_valid = (state_q == DCR_WRITE);
    assign dcr_write_addr  = dcr_write_valid ? STARTUP_DCR_ADDR : '0;
    assign dcr_write_data  = dcr_write_valid ? STARTUP_ADDR : '0;
    assign seq_busy        = (state_q != RUN);
    assign seq_done        = (state_q == RUN);

endmodule

// File: tb/tb_vx_reset_sequencer.sv
// Directed testbench for vx_reset_sequencer at default parameters.
// With VX_RESET_SEQ_TIMEOUT_EN defined the DUT gets LOAD_TIMEOUT_CYCLES=16
// and the final scenario expects the timeout path instead of an endless wait.
`timescale 1ns/1ps
module tb_vx_reset_sequencer;

    localparam logic [11:0] EXP_ADDR = 12'h001;
    localparam logic [31:0] EXP_DATA = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        soft_reset_req;
    logic        load_done;
    logic [6:0]  domain_reset;
    logic        dcr_write_valid;
    logic [11:0] dcr_write_addr;
    logic [31:0] dcr_write_data;
    logic        seq_busy;
    logic        seq_done;
    logic        load_timeout;

    int total = 0;
    int bad   = 0;

    vx_reset_sequencer #(
        .NUM_DOMAINS (7)
`ifdef VX_RESET_SEQ_TIMEOUT_EN
        ,
        .LOAD_TIMEOUT_CYCLES (16)
`endif
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .soft_reset_req  (soft_reset_req),
        .load_done       (load_done),
        .domain_reset    (domain_reset),
        .dcr_write_valid (dcr_write_valid),
        .dcr_write_addr  (dcr_write_addr),
        .dcr_write_data  (dcr_write_data),
        .seq_busy        (seq_busy),
        .seq_done        (seq_done),
        .load_timeout    (load_timeout)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Holds reset_n low for three cycles, checks reset values, and releases
    // it at a falling edge so the next rising edge is edge 1.
    task automatic applyReset();
        @(negedge clk);
        reset_n        = 1'b0;
        soft_reset_req = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_dom",   32'(domain_reset),    32'h7F);
        checkOutput("rst_valid", 32'(dcr_write_valid), 32'h0);
        checkOutput("rst_addr",  32'(dcr_write_addr),  32'h0);
        checkOutput("rst_data",  dcr_write_data,       32'h0);
        checkOutput("rst_busy",  32'(seq_busy),        32'h1);
        checkOutput("rst_done",  32'(seq_done),        32'h0);
        checkOutput("rst_to",    32'(load_timeout),    32'h0);
        reset_n = 1'b1;
    endtask

    // Runs edges 1..N of a sequence and checks every output after each edge.
    // loadEdge : edge at which load_done is first sampled high (1 = already high, 0 = never)
    // exitEdge : edge at which WAIT_LOAD is left (DCR write visible right after it)
    // softEdge : edge at which a soft_reset_req pulse is sampled (0 = none)
    // toEdge   : edge after which load_timeout reads 1 (0 = never)
    // stopEdge : last edge to run (0 = run into RUN for two extra edges)
    task automatic applyStimulus(input int loadEdge, input int exitEdge, input int softEdge,
                                 input int toEdge, input int stopEdge);
        int         rel[7];
        int         lastEdge;
        logic [6:0] expDom;
        logic       expValid;
        rel      = '{4, 6, exitEdge + 3, exitEdge + 5, exitEdge + 7, exitEdge + 9, exitEdge + 11};
        lastEdge = (stopEdge > 0) ? stopEdge : exitEdge + 13;
        if (loadEdge == 1) load_done = 1'b1;
        for (int e = 1; e <= lastEdge; e++) begin
            if (loadEdge > 1 && e == loadEdge) load_done = 1'b1;
            soft_reset_req = (e == softEdge);
            @(posedge clk);
            #1;
            for (int i = 0; i < 7; i++) expDom[i] = (e < rel[i]);
            expValid = (e == exitEdge);
            checkOutput($sformatf("dom@%0d", e),   32'(domain_reset),    32'(expDom));
            checkOutput($sformatf("valid@%0d", e), 32'(dcr_write_valid), 32'(expValid));
            checkOutput($sformatf("addr@%0d", e),  32'(dcr_write_addr),  expValid ? 32'(EXP_ADDR) : 32'h0);
            checkOutput($sformatf("data@%0d", e),  dcr_write_data,       expValid ? EXP_DATA : 32'h0);
            checkOutput($sformatf("busy@%0d", e),  32'(seq_busy),        32'(e < rel[6]));
            checkOutput($sformatf("done@%0d", e),  32'(seq_done),        32'(e >= rel[6]));
            checkOutput($sformatf("to@%0d", e),    32'(load_timeout),    32'(toEdge > 0 && e >= toEdge));
        end
        soft_reset_req = 1'b0;
    endtask

    // Pulses soft_reset_req for one edge while in RUN and checks the restart.
    task automatic applySoftPulse(input logic expTimeout);
        @(negedge clk);
        load_done      = 1'b0;
        soft_reset_req = 1'b1;
        @(posedge clk);
        #1;
        soft_reset_req = 1'b0;
        checkOutput("soft_dom",  32'(domain_reset), 32'h7F);
        checkOutput("soft_busy", 32'(seq_busy),     32'h1);
        checkOutput("soft_done", 32'(seq_done),     32'h0);
        checkOutput("soft_to",   32'(load_timeout), 32'(expTimeout));
    endtask

    // Drops reset_n between clock edges and checks outputs before the next edge.
    task automatic applyMidReset(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput({tag, "_dom"},   32'(domain_reset),    32'h7F);
        checkOutput({tag, "_valid"}, 32'(dcr_write_valid), 32'h0);
        checkOutput({tag, "_addr"},  32'(dcr_write_addr),  32'h0);
        checkOutput({tag, "_busy"},  32'(seq_busy),        32'h1);
        checkOutput({tag, "_done"},  32'(seq_done),        32'h0);
    endtask

    // Scenario list: power-up, early load_done, soft reset, async reset, preload stall.
    initial begin
        reset_n        = 1'b0;
        soft_reset_req = 1'b0;
        load_done      = 1'b0;

        $display("[TB] power-up with load_done at edge 8");
        applyReset();
        applyStimulus(8, 8, 0, 0, 0);

        $display("[TB] load_done already high at edge 1");
        load_done = 1'b1;
        applyReset();
        applyStimulus(1, 7, 0, 0, 0);

        $display("[TB] soft reset in RUN, re-await load_done, soft pulse in RELEASE_PRE ignored");
        applySoftPulse(1'b0);
        applyStimulus(12, 12, 5, 0, 0);

        $display("[TB] reset_n asserted during RELEASE_POST");
        load_done = 1'b0;
        applyReset();
        applyStimulus(8, 8, 0, 0, 12);
        applyMidReset("post_rst");

        $display("[TB] reset_n asserted during the DCR write cycle");
        load_done = 1'b0;
        applyReset();
        applyStimulus(8, 8, 0, 0, 8);
        applyMidReset("dcr_rst");

        load_done = 1'b0;
        applyReset();
`ifdef VX_RESET_SEQ_TIMEOUT_EN
        $display("[TB] load_done held low, timeout after 16 WAIT_LOAD edges");
        applyStimulus(0, 22, 0, 22, 0);
        applySoftPulse(1'b1);
`else
        $display("[TB] load_done held low, sequencer keeps waiting");
        applyStimulus(0, 99, 0, 0, 40);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
